// File: rtl/states_pkg.sv
// ============================================================================
// Module      : states_pkg
// Description : Shared scheduler/fetcher state encodings and fetch defaults.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package states_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    REQUEST   = 3'd3,
    WAIT      = 3'd4,
    EXECUTE   = 3'd5,
    UPDATE    = 3'd6,
    CORE_DONE = 3'd7
  } core_state_t;

  typedef enum logic [2:0] {
    FETCH_IDLE = 3'd0,
    FETCHING   = 3'd1,
    FETCHED    = 3'd2
  } fetcher_state_t;

  localparam int unsigned INSTR_CACHE_LINES_DEFAULT = 8;

endpackage : states_pkg

`default_nettype wire

// File: rtl/instr_cache.sv
// ============================================================================
// Module      : instr_cache
// Description : Direct-mapped instruction buffer; built only with INSTR_CACHE_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

`ifdef INSTR_CACHE_EN
module instr_cache
  import states_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned LINES     = INSTR_CACHE_LINES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] lookup_pc_i,
  output logic                 lookup_hit_o,
  output logic [DATA_BITS-1:0] lookup_data_o,
  input  logic                 fill_valid_i,
  input  logic [ADDR_BITS-1:0] fill_pc_i,
  input  logic [DATA_BITS-1:0] fill_data_i,
  input  logic                 flush_i
);

  localparam int unsigned IDX_BITS = $clog2(LINES);
  localparam int unsigned TAG_BITS = ADDR_BITS - IDX_BITS;

  logic [LINES-1:0]     valid_q;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [DATA_BITS-1:0] data_q [LINES];

  logic [IDX_BITS-1:0]  w_lookup_idx;
  logic [TAG_BITS-1:0]  w_lookup_tag;
  logic [IDX_BITS-1:0]  w_fill_idx;
  logic [TAG_BITS-1:0]  w_fill_tag;

  assign w_lookup_idx = lookup_pc_i[IDX_BITS-1:0];
  assign w_lookup_tag = lookup_pc_i[ADDR_BITS-1:IDX_BITS];
  assign w_fill_idx   = fill_pc_i[IDX_BITS-1:0];
  assign w_fill_tag   = fill_pc_i[ADDR_BITS-1:IDX_BITS];

  // A flush in the lookup cycle forces a miss so no stale line is returned.
  assign lookup_hit_o  = valid_q[w_lookup_idx] && (tag_q[w_lookup_idx] == w_lookup_tag) && !flush_i;
  assign lookup_data_o = data_q[w_lookup_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (fill_valid_i) begin
      valid_q[w_fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_valid_i && !flush_i) begin
      tag_q[w_fill_idx]  <= w_fill_tag;
      data_q[w_fill_idx] <= fill_data_i;
    end
  end

endmodule : instr_cache
`endif

`default_nettype wire

// File: rtl/instr_fetcher.sv
// ============================================================================
// Module      : instr_fetcher
// Description : Per-core instruction fetch stage; optional buffer via INSTR_CACHE_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module instr_fetcher
  import states_pkg::*;
#(
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
  parameter int unsigned PROGRAM_MEM_DATA_BITS = 16,
  parameter int unsigned CACHE_LINES           = INSTR_CACHE_LINES_DEFAULT
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             cache_flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

  fetcher_state_t                   state_q, state_d;
  logic                             valid_q, valid_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_q,  addr_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q, instr_d;

  core_state_t                      w_core;
  logic                             w_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] w_hit_data;
  logic                             w_fill;

  assign w_core = core_state_t'(core_state);

`ifdef INSTR_CACHE_EN
  instr_cache #(
    .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
    .DATA_BITS (PROGRAM_MEM_DATA_BITS),
    .LINES     (CACHE_LINES)
  ) u_instr_cache (
    .clk           (clk),
    .reset         (reset),
    .lookup_pc_i   (current_pc),
    .lookup_hit_o  (w_hit),
    .lookup_data_o (w_hit_data),
    .fill_valid_i  (w_fill),
    .fill_pc_i     (addr_q),
    .fill_data_i   (mem_read_data),
    .flush_i       (cache_flush)
  );
`else
  logic unused_nocache;
  assign w_hit          = 1'b0;
  assign w_hit_data     = '0;
  assign unused_nocache = ^{cache_flush, w_fill, CACHE_LINES[0]};
`endif

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    w_fill  = 1'b0;
    unique case (state_q)
      FETCH_IDLE: begin
        if (w_core == FETCH) begin
          if (w_hit) begin
            instr_d = w_hit_data;
            state_d = FETCHED;
          end else begin
            valid_d = 1'b1;
            addr_d  = current_pc;
            state_d = FETCHING;
          end
        end
      end
      FETCHING: begin
        // The request runs to completion regardless of the scheduler state.
        if (mem_read_ready) begin
          instr_d = mem_read_data;
          valid_d = 1'b0;
          w_fill  = 1'b1;
          state_d = FETCHED;
        end
      end
      FETCHED: begin
        if (w_core == DECODE) begin
          state_d = FETCH_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = FETCH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH_IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
    end
  end

  assign mem_read_valid   = valid_q;
  assign mem_read_address = addr_q;
  assign fetcher_state    = state_q;
  assign instruction      = instr_q;

endmodule : instr_fetcher

`default_nettype wire

// File: tb/tb_instr_fetcher.sv
// ============================================================================
// Module      : tb_instr_fetcher
// Description : Scoreboard bench for instr_fetcher (honours INSTR_CACHE_EN).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetcher;
  import states_pkg::*;

  localparam int CL = 8;
`ifdef INSTR_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        cache_flush;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;

  logic        resp_ready = 1'b0;
  logic        stray_ready = 1'b0;
  logic [15:0] resp_data = '0;
  logic [15:0] junk = '0;
  logic [7:0]  resp_addr = '0;
  bit          flush_rand = 1'b0;
  bit          in_rst_test = 1'b0;
  logic        rst_seen = 1'b1;

  always #5 clk = ~clk;

  assign mem_read_ready = resp_ready | stray_ready;
  assign mem_read_data  = resp_ready ? resp_data : junk;

  instr_fetcher dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .cache_flush      (cache_flush),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction)
  );

  int passed = 0;
  int total  = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [15:0] instr;
    int unsigned done;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] req_q[$];
  int         lat_q[$];
  logic [15:0] mem [256];

  // Reference buffer: which PCs a correct design would currently hold.
  bit         mv [CL];
  logic [4:0] mt [CL];

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
    if (reset || cache_flush) begin
      for (int i = 0; i < CL; i++) mv[i] <= 1'b0;
    end else if (resp_ready && !in_rst_test) begin
      mv[resp_addr[2:0]] <= 1'b1;
      mt[resp_addr[2:0]] <= resp_addr[7:3];
    end
  end

  function automatic bit model_hit(input logic [7:0] pc);
    return CACHE_ON && !cache_flush && mv[pc[2:0]] && (mt[pc[2:0]] == pc[7:3]);
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(negedge clk);
    stray_ready = 1'b0;
    cache_flush = flush_rand ? ($urandom_range(0, 9) == 0) : 1'b0;
  endtask

  function automatic logic [2:0] idle_state();
    logic [2:0] v;
    v = 3'($urandom_range(2, 7));
    if (v == 3'd2) v = 3'd0;
    return v;
  endfunction

  // Issue one fetch, see it through to FETCHED, then hand it to DECODE.
  task automatic fetch_txn(input logic [7:0] pc, input int lat, input bit flush_on_fill);
    bit hit;
    int unsigned c0;
    int n, k;
    exp_t e;
    tick();
    hit        = model_hit(pc);
    core_state = FETCH;
    current_pc = pc;
    c0         = cyc;
    if (!hit) begin
      req_q.push_back(pc);
      lat_q.push_back(lat);
    end
    e.instr = mem[pc];
    e.done  = hit ? c0 + 1 : c0 + 2 + lat;
    exp_q.push_back(e);
    n = 0;
    do begin
      tick();
      n++;
      if (flush_on_fill && !hit && cyc == c0 + 1 + lat) cache_flush = 1'b1;
      if (fetcher_state != FETCHED) begin
        core_state = 3'($urandom_range(0, 7));
        current_pc = 8'($urandom);
      end
    end while (fetcher_state != FETCHED && n < 100);
    if (fetcher_state != FETCHED) check("fetch timeout", 32'(fetcher_state), 32'(FETCHED));
    k = $urandom_range(0, 3);
    for (int i = 0; i < k; i++) begin
      core_state = idle_state();
      if ($urandom_range(0, 1) == 1) begin
        stray_ready = 1'b1;
        junk        = 16'($urandom);
      end
      tick();
      check("stay fetched", 32'(fetcher_state), 32'(FETCHED));
    end
    core_state = DECODE;
    tick();
    check("idle after decode", 32'(fetcher_state), 32'(FETCH_IDLE));
    core_state = idle_state();
    if ($urandom_range(0, 1) == 1) begin
      stray_ready = 1'b1;
      junk        = 16'($urandom);
    end
  endtask

  // Memory responder: serves each request after the latency chosen by the stimulus.
  initial begin
    logic [7:0] a;
    int l;
    forever begin
      @(negedge clk);
      if (mem_read_valid === 1'b1) begin
        if (req_q.size() == 0) begin
          check("unexpected request", 1, 0);
          a = mem_read_address;
          l = 0;
        end else begin
          a = req_q.pop_front();
          l = lat_q.pop_front();
          check("request address", 32'(mem_read_address), 32'(a));
        end
        for (int i = 0; i < l; i++) begin
          @(negedge clk);
          if (!in_rst_test) begin
            check("valid held", 32'(mem_read_valid), 1);
            check("address held", 32'(mem_read_address), 32'(a));
          end
        end
        resp_addr  = a;
        resp_data  = mem[a];
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        resp_data  = 16'($urandom);
      end
    end
  end

  // Monitor: every completed fetch is scored; otherwise the instruction must hold.
  initial begin
    logic [2:0]  ps;
    logic [15:0] pi;
    exp_t e;
    ps = '0;
    pi = '0;
    forever begin
      @(negedge clk);
      if (rst_seen !== 1'b0) begin
      end else if (fetcher_state == FETCHED && ps != FETCHED) begin
        if (exp_q.size() == 0) begin
          check("unexpected FETCHED", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("instruction", 32'(instruction), 32'(e.instr));
          check("fetch latency", cyc, e.done);
        end
      end else begin
        check("instruction hold", 32'(instruction), 32'(pi));
      end
      ps = fetcher_state;
      pi = instruction;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h05] = 16'h3A7C;
    mem[8'h12] = 16'hBEEF;
    reset       = 1'b1;
    core_state  = CORE_IDLE;
    current_pc  = '0;
    cache_flush = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset state", 32'(fetcher_state), 32'(FETCH_IDLE));
    check("reset valid", 32'(mem_read_valid), 0);
    check("reset address", 32'(mem_read_address), 0);
    check("reset instruction", 32'(instruction), 0);

    fetch_txn(8'h05, 3, 1'b0);
    fetch_txn(8'h00, 0, 1'b0);
    fetch_txn(8'h01, 0, 1'b0);
    fetch_txn(8'h12, 2, 1'b0);
    fetch_txn(8'h12, 1, 1'b0);
    fetch_txn(8'h1A, 1, 1'b0);
    fetch_txn(8'h03, 0, 1'b0);
    tick();
    cache_flush = 1'b1;
    fetch_txn(8'h03, 1, 1'b0);
    fetch_txn(8'h07, 2, 1'b1);
    fetch_txn(8'h07, 0, 1'b0);

    flush_rand = 1'b1;
    for (int t = 0; t < 60; t++) begin
      logic [7:0] pc;
      pc = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom_range(0, 23));
      fetch_txn(pc, $urandom_range(0, 4), ($urandom_range(0, 5) == 0));
    end

    // Reset lands in the second FETCHING cycle; the late response must be ignored.
    flush_rand  = 1'b0;
    in_rst_test = 1'b1;
    tick();
    core_state = CORE_IDLE;
    tick();
    core_state = FETCH;
    current_pc = 8'h40;
    if (!model_hit(8'h40)) begin
      req_q.push_back(8'h40);
      lat_q.push_back(6);
    end
    tick();
    core_state = CORE_IDLE;
    check("reset test request", 32'(mem_read_valid), 32'(!model_hit(8'h40)));
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid reset valid", 32'(mem_read_valid), 0);
    check("mid reset state", 32'(fetcher_state), 32'(FETCH_IDLE));
    check("mid reset instruction", 32'(instruction), 0);
    repeat (8) tick();
    check("late ready state", 32'(fetcher_state), 32'(FETCH_IDLE));
    check("late ready instruction", 32'(instruction), 0);
    check("late ready valid", 32'(mem_read_valid), 0);
    exp_q.delete();
    check("pending requests", 32'(req_q.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_instr_fetcher

`default_nettype wire

// File: doc/instr_fetcher.md
Name: instr_fetcher

Overview:
Per-core instruction fetch stage. It sits directly upstream of the core scheduler and downstream of the program-memory controller channel. When the core enters FETCH, it reads the instruction at current_pc from program memory and holds it for the decoder. It reports progress on fetcher_state, which the scheduler polls to leave FETCH.

Parameters:
PROGRAM_MEM_ADDR_BITS, 8, width of program-memory address and current_pc
PROGRAM_MEM_DATA_BITS, 16, instruction width
CACHE_LINES, 8, number of instruction-buffer entries (power of 2, >=2); used only with INSTR_CACHE_EN

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
core_state  in  3  scheduler state, core_state_t encoding
current_pc  in  PROGRAM_MEM_ADDR_BITS  PC to fetch
cache_flush  in  1  invalidate all buffered instructions; ignored without INSTR_CACHE_EN
mem_read_valid  out  1  read request to program-memory controller
mem_read_address  out  PROGRAM_MEM_ADDR_BITS  request address
mem_read_ready  in  1  read data valid, one-cycle pulse
mem_read_data  in  PROGRAM_MEM_DATA_BITS  returned instruction
fetcher_state  out  3  fetcher_state_t encoding
instruction  out  PROGRAM_MEM_DATA_BITS  fetched instruction, held stable until the next fetch completes

Behaviour:
- Clocking and reset: single clock domain; all state updates on posedge clk. Synchronous, active-high reset.
- Reset values: fetcher_state=FETCH_IDLE, mem_read_valid=0, mem_read_address=0, instruction=0. With INSTR_CACHE_EN, all cache valid bits are also cleared.
- FETCH_IDLE: when core_state==FETCH:
  - Register mem_read_valid<=1 and mem_read_address<=current_pc.
  - Move to FETCHING.
  - First request is visible the cycle after FETCH is seen.
- FETCHING:
  - mem_read_valid stays 1 and the address stays stable until mem_read_ready.
  - On mem_read_ready: instruction<=mem_read_data, mem_read_valid<=0, go to FETCHED.
  - Ready and data are captured in the same cycle.
- FETCHED:
  - Hold instruction.
  - When core_state==DECODE, go to FETCH_IDLE. Otherwise stay in FETCHED.
- Latency: FETCH seen to FETCHED visible is memory latency + 2 cycles minimum (ready in the first FETCHING cycle gives FETCHED 2 cycles after FETCH is seen).
- Protocol corner cases:
  - mem_read_ready while not in FETCHING is ignored.
  - core_state values other than FETCH/DECODE do not move the FSM.
  - core_state leaving FETCH while in FETCHING does not abort the request; it completes normally.
- Reset mid-request: mem_read_valid drops the next cycle and the outstanding response is discarded. The memory controller is reset by the same reset.
- Widths: address is passed through unmodified; no arithmetic on PC.

Optional Feature:
Macro INSTR_CACHE_EN.
- Enabled:
  - Direct-mapped buffer of CACHE_LINES entries.
  - index = current_pc[log2(CACHE_LINES)-1:0]; tag = remaining upper PC bits; one valid bit per line.
  - FETCH_IDLE with core_state==FETCH and hit: instruction<=line data, go straight to FETCHED with no memory request (1-cycle fetch).
  - Miss: normal request path. On mem_read_ready the line is filled (data, tag, valid=1).
  - cache_flush clears all valid bits the next cycle and has priority over a fill in the same cycle; that fill is dropped, but the instruction is still delivered.
  - A lookup in the same cycle as cache_flush is treated as a miss.
- Disabled: no storage, cache_flush unused, every fetch goes to memory.

Decomposition:
- states_pkg (existing) holds:
  - core_state_t (CORE_IDLE, FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE, CORE_DONE).
  - fetcher_state_t (FETCH_IDLE, FETCHING, FETCHED), 3-bit.
  - Add the constant INSTR_CACHE_LINES_DEFAULT=8.
- One sub-module, instr_cache, compiled only under INSTR_CACHE_EN:
  - Lookup port: pc in; hit and data out (combinational).
  - Fill port: valid, pc, data.
  - Flush input.
  - Synchronous reset.

Test Plan:
- Basic fetch: core_state=FETCH, pc=0x05, memory returns 0x3A7C three cycles after the request → mem_read_valid=1 with address 0x05 until ready; fetcher_state=FETCHED; instruction=0x3A7C; after core_state=DECODE, back to FETCH_IDLE.
- Back-to-back fetch: pc 0x00 then 0x01, ready in the first FETCHING cycle → FETCHED 2 cycles after each FETCH; instruction updates to the second word only when its ready arrives.
- Stray ready: mem_read_ready=1 while in FETCH_IDLE and FETCHED → state and instruction unchanged.
- Reset mid-request: reset in the second FETCHING cycle → next cycle mem_read_valid=0, FETCH_IDLE, instruction=0; a late ready is ignored.
- INSTR_CACHE_EN hit/miss: fetch pc 0x12 (miss, memory returns 0xBEEF), then fetch 0x12 again → no request on the second fetch, FETCHED one cycle after FETCH, instruction=0xBEEF. Then fetch 0x1A (same index, different tag) → miss and memory request.
- INSTR_CACHE_EN flush: fill pc 0x03, pulse cache_flush, refetch 0x03 → memory request issued. Flush coincident with a fill → line not valid afterwards, but the instruction is still delivered.
